// File: rtl/serv_decode_q.sv
// rtl/serv_decode_q.sv - fetch queue feeding a registered SERV instruction decoder
module serv_decode_q #(
  parameter int DEPTH = 2,
  parameter int MDU   = 0
) (
  input  logic                         clk,
  input  logic                         i_rst,
  input  logic [31:0]                  i_wb_rdt,
  input  logic                         i_wb_en,
  output logic                         o_ibus_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  input  logic                         i_adv,
  input  logic                         i_flush,
  output logic                         o_valid,
  output logic                         o_illegal,
  output logic                         o_mdu_op,
  output logic [4:0]                   o_opcode,
  output logic [2:0]                   o_funct3,
  output logic                         o_rd_op,
  output logic                         o_dbus_en,
  output logic                         o_branch_op,
  output logic                         o_cond_branch,
  output logic                         o_mem_cmd,
  output logic                         o_csr_op,
  output logic                         o_e_op,
  output logic                         o_ctrl_mret,
  output logic                         o_alu_sub,
  output logic                         o_two_stage_op
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic [31:0]   r_ir;
  logic          r_valid;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_load;
  logic w_pop;
  logic w_bypass;
  logic w_write;

  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Readiness looks only at the registered level so it never depends on i_adv.
  assign w_full    = (r_level == FULL_LVL);
  assign w_empty   = (r_level == '0);
  assign w_push_ok = i_wb_en & ~w_full;
  assign w_load    = ~r_valid | i_adv;
  assign w_pop     = w_load & ~w_empty;
  assign w_bypass  = w_load & w_empty & w_push_ok;
  assign w_write   = w_push_ok & ~w_bypass & ~i_flush & ~i_rst;

  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wptr] <= i_wb_rdt;
  end

  always_ff @(posedge clk) begin
    if (i_rst | i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ir    <= '0;
      r_valid <= 1'b0;
    end else begin
      if (w_write) r_wptr <= f_inc(r_wptr);
      if (w_pop)   r_rptr <= f_inc(r_rptr);
      if (w_write & ~w_pop)      r_level <= r_level + 1'b1;
      else if (~w_write & w_pop) r_level <= r_level - 1'b1;
      if (w_pop) begin
        r_ir    <= r_mem[r_rptr];
        r_valid <= 1'b1;
      end else if (w_bypass) begin
        r_ir    <= i_wb_rdt;
        r_valid <= 1'b1;
      end else if (w_load) begin
        r_valid <= 1'b0;
      end
    end
  end

  logic [4:0] w_op;
  logic [2:0] w_f3;
  logic [6:0] w_f7;
  logic       w_legal_op;
  logic       w_mdu;
  logic       w_legal;
  logic       w_en;
  logic       w_unused;

  assign w_op     = r_ir[6:2];
  assign w_f3     = r_ir[14:12];
  assign w_f7     = r_ir[31:25];
  assign w_unused = ^{r_ir[24:22], r_ir[20:15], r_ir[11:7]};

  always_comb begin
    w_legal_op = 1'b0;
    case (w_op)
      5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
      5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100: w_legal_op = 1'b1;
      default: w_legal_op = 1'b0;
    endcase
  end

  assign w_mdu   = (MDU != 0) && (w_op == 5'b01100) && (w_f7 == 7'b0000001);
  assign w_legal = (r_ir[1:0] == 2'b11) && w_legal_op &&
                   ((w_op != 5'b01100) || (w_f7 == 7'b0000000) ||
                    (w_f7 == 7'b0100000) || w_mdu);
  assign w_en    = r_valid & w_legal;

  assign o_ibus_ready   = ~w_full;
  assign o_level        = r_level;
  assign o_valid        = r_valid;
  assign o_illegal      = r_valid & ~w_legal;
  assign o_opcode       = r_valid ? w_op : 5'b0;
  assign o_funct3       = r_valid ? w_f3 : 3'b0;
  assign o_mdu_op       = w_en & w_mdu;
  assign o_rd_op        = w_en & (w_op[2] | (w_op[4] & w_op[0]) | (~w_op[3] & ~w_op[0]));
  assign o_dbus_en      = w_en & ~w_op[2] & ~w_op[4];
  assign o_branch_op    = w_en & w_op[4];
  assign o_cond_branch  = w_en & w_op[4] & ~w_op[2] & ~w_op[0];
  assign o_mem_cmd      = w_en & w_op[3];
  assign o_csr_op       = w_en & w_op[4] & w_op[2] & (w_f3 != 3'b0);
  assign o_e_op         = w_en & w_op[4] & w_op[2] & ~r_ir[21] & (w_f3 == 3'b0);
  assign o_ctrl_mret    = w_en & w_op[4] & w_op[2] & r_ir[21] & (w_f3 == 3'b0);
  assign o_alu_sub      = w_en & (w_f3[1] | w_f3[0] | (w_op[3] & r_ir[30]) | w_op[4]);
  assign o_two_stage_op = w_en & (~w_op[2] |
                                  (~w_op[4] & ~w_op[0] &
                                   ((w_f3[0] & ~w_f3[1]) | (w_f3[1] & ~w_f3[2]))) |
                                  w_mdu);

endmodule
